// File: rtl/tap_step_commander_if.sv
// rtl/tap_step_commander_if.sv - request handshake and pattern output bundle for tap_step_commander
interface tap_step_commander_if;
  logic       req_valid;
  logic [2:0] req_pos;
  logic       req_ready;
  logic       halt;
  logic [5:0] vnew;
  logic       dir;
  logic [2:0] pos;
  logic       busy;
  logic       done;
  logic       err;

  // Requester side: issues targets and halt, observes progress.
  modport master (
    output req_valid, req_pos, halt,
    input  req_ready, vnew, dir, pos, busy, done, err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_pos, halt,
    output req_ready, vnew, dir, pos, busy, done, err
  );
endinterface

// File: rtl/tap_step_commander.sv
// rtl/tap_step_commander.sv - walks the 6-bit switch pattern one position per dwell toward a requested target
module tap_step_commander #(
  parameter int DWELL = 8,
  parameter int NPOS  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  tap_step_commander_if.slave  bus
);

  // Reject parameter values the pattern table and dwell counter cannot honour.
  generate
    if (DWELL < 4 || DWELL > 255) begin : g_bad_dwell
      $error("tap_step_commander: DWELL must be in 4..255");
    end
    if (NPOS != 6) begin : g_bad_npos
      $error("tap_step_commander: NPOS must be 6");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] NPOS_W     = 4'(NPOS);
  localparam logic [5:0] VNEW_RST   = 6'b000011;

  state_t     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic [2:0] tgt_q, tgt_d;
  logic [5:0] vnew_q, vnew_d;
  logic       dir_q, dir_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] step_pos;

  // Position to switch pattern; neighbours share exactly one set bit.
  function automatic logic [5:0] pattern(input logic [2:0] p);
    logic [5:0] v;
    case (p)
      3'd0:    v = 6'b000011;
      3'd1:    v = 6'b000110;
      3'd2:    v = 6'b001100;
      3'd3:    v = 6'b011000;
      3'd4:    v = 6'b110000;
      3'd5:    v = 6'b100001;
      default: v = 6'b000011;
    endcase
    return v;
  endfunction

  // Next-state and next-output decode; vnew/dir only move in STEP.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    tgt_d    = tgt_q;
    vnew_d   = vnew_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    step_pos = pos_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if ({1'b0, bus.req_pos} >= NPOS_W) begin
            err_d = 1'b1;
          end else if (bus.req_pos == pos_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = bus.req_pos;
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (tgt_q > pos_q) begin
          step_pos = pos_q + 3'd1;
          dir_d    = 1'b1;
        end else begin
          step_pos = pos_q - 3'd1;
          dir_d    = 1'b0;
        end
        pos_d   = step_pos;
        vnew_d  = pattern(step_pos);
        cnt_d   = DWELL_LAST;
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (cnt_q == 8'd0) begin
          // Halt is honoured only here so a pattern is never cut short.
          if (pos_q == tgt_q || bus.halt) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_STEP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pos_q   <= 3'd0;
      tgt_q   <= 3'd0;
      vnew_q  <= VNEW_RST;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      vnew_q  <= vnew_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.vnew      = vnew_q;
  assign bus.dir       = dir_q;
  assign bus.pos       = pos_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_tap_step_commander.sv
// tb/tb_tap_step_commander.sv - randomized self-checking bench for tap_step_commander
module tb_tap_step_commander;

  localparam int DWELL = 8;
  localparam int P     = DWELL + 1;

  logic clk = 1'b0;
  logic rst;

  tap_step_commander_if bus ();

  tap_step_commander #(.DWELL(DWELL), .NPOS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_pos  = 0;
  int m_dir  = 0;

  function automatic int pat(int p);
    return (p == 5) ? 33 : (3 << p);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_outputs(string tag, int e_pos, int e_dir, int e_busy, int e_done, int e_err);
    chk({tag, ".pos"},   32'(bus.pos),       32'(e_pos));
    chk({tag, ".vnew"},  32'(bus.vnew),      32'(pat(e_pos)));
    chk({tag, ".dir"},   32'(bus.dir),       32'(e_dir));
    chk({tag, ".busy"},  32'(bus.busy),      32'(e_busy));
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(1 - e_busy));
    chk({tag, ".done"},  32'(bus.done),      32'(e_done));
    chk({tag, ".err"},   32'(bus.err),       32'(e_err));
  endtask

  // Issue one request from a negedge and check every cycle until one past completion.
  task automatic run_req(int target, int halt_step, bit halt_pre, int junk_n);
    int start, k, kh, big_k, dirn, steps, e_pos, e_dir;
    string tag;
    start = m_pos;
    if (target >= 6) begin
      bus.req_valid = 1'b1;
      bus.req_pos   = 3'(target);
      @(posedge clk); @(negedge clk);
      bus.req_valid = 1'b0;
      chk_outputs($sformatf("rej%0d", target), m_pos, m_dir, 0, 0, 1);
      @(posedge clk); @(negedge clk);
      chk_outputs($sformatf("rej%0d.after", target), m_pos, m_dir, 0, 0, 0);
      return;
    end
    k     = (target > start) ? target - start : start - target;
    dirn  = (target > start) ? 1 : 0;
    kh    = k;
    if (halt_pre && k > 1) kh = 1;
    else if (halt_step > 0 && halt_step < k) kh = halt_step;
    big_k = kh * P;
    if (halt_pre) bus.halt = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_pos   = 3'(target);
    e_pos = start;
    for (int n = 0; n <= big_k + 1; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 0) bus.req_valid = 1'b0;
      steps = (n == 0) ? 0 : ((n - 1) / P + 1);
      if (steps > kh) steps = kh;
      e_pos = dirn ? start + steps : start - steps;
      e_dir = (steps > 0) ? dirn : m_dir;
      tag   = $sformatf("req%0d->%0d.n%0d", start, target, n);
      chk_outputs(tag, e_pos, e_dir, (n < big_k) ? 1 : 0, (n == big_k) ? 1 : 0, 0);
      if (halt_step > 0 && n == (halt_step - 1) * P + 3 && n < big_k) bus.halt = 1'b1;
      if (n == big_k) bus.halt = 1'b0;
      if (junk_n > 0 && n == junk_n && n < big_k) begin
        bus.req_valid = 1'b1;
        bus.req_pos   = 3'($urandom_range(0, 7));
      end else if (junk_n > 0 && n == junk_n + 1) begin
        bus.req_valid = 1'b0;
      end
    end
    m_pos = e_pos;
    if (kh > 0) m_dir = dirn;
  endtask

  // Directed scenarios followed by randomized requests.
  initial begin
    int tgt, hs, jn;
    bit pre;
    bus.req_valid = 1'b0;
    bus.req_pos   = 3'd0;
    bus.halt      = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outputs("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_outputs("idle", 0, 0, 0, 0, 0);

    run_req(3, 0, 1'b0, 0);
    run_req(5, 0, 1'b0, 4);
    run_req(0, 0, 1'b0, 0);
    run_req(6, 0, 1'b0, 0);
    run_req(7, 0, 1'b0, 0);
    run_req(0, 0, 1'b0, 0);
    run_req(4, 2, 1'b0, 5);
    run_req(0, 0, 1'b0, 0);
    run_req(3, 0, 1'b1, 0);
    run_req(0, 0, 1'b0, 0);

    // Reset during the second dwell of a 0 -> 2 walk.
    bus.req_valid = 1'b1;
    bus.req_pos   = 3'd2;
    for (int n = 0; n <= 12; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 0) bus.req_valid = 1'b0;
    end
    chk_outputs("midwalk", 2, 1, 1, 0, 0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk_outputs("midrst", 0, 0, 0, 0, 0);
    m_pos = 0;
    m_dir = 0;
    @(posedge clk); @(negedge clk);
    chk_outputs("midrst.after", 0, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      tgt = $urandom_range(0, 7);
      hs  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      pre = ($urandom_range(0, 7) == 0);
      jn  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
      run_req(tgt, hs, pre, jn);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tap_step_commander.md
# tap_step_commander

Upstream sequencer for the four-step switch-transition stage. Accepts target-position requests over a valid/ready handshake and walks the 6-bit switch pattern one position at a time toward the target. For each step it presents a new pattern on `vnew` with the matching `dir`, then holds both stable for a programmable dwell. The dwell gives the downstream transition stage time to complete its four-cycle sequence before the next change.

## Interface
- `DWELL`, 8: cycles the pattern is held after each step (legal range 4..255); an elaboration-time check rejects values outside that range
- `NPOS`, 6: number of valid positions (fixed table below; values other than 6 are illegal)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  1  target request present
- `req_pos`  in  3  requested target position
- `req_ready`  out  1  high only in IDLE
- `halt`  in  1  stop after the current dwell; level-sensitive
- `vnew`  out  6  switch pattern to the downstream transition stage
- `dir`  out  1  1 = last step increased position, 0 = decreased
- `pos`  out  3  current position index
- `busy`  out  1  high in STEP or DWELL
- `done`  out  1  one-cycle pulse when a request finishes or is halted
- `err`  out  1  one-cycle pulse when a request is rejected

## Operation
- Pattern table (pos -> vnew):
  - 0 -> 000011
  - 1 -> 000110
  - 2 -> 001100
  - 3 -> 011000
  - 4 -> 110000
  - 5 -> 100001
- Adjacent patterns share exactly one set bit.
- Reset values: state IDLE, `pos`=0, `vnew`=000011, `dir`=0, `done`=0, `err`=0, dwell counter 0, latched target 0.
- Reset mid-operation forces these values on the next edge, regardless of state.
- State IDLE (`req_ready`=1): on an edge with `req_valid` high:
  - `req_pos` >= NPOS: pulse `err`, stay IDLE.
  - `req_pos` == `pos`: pulse `done`, stay IDLE; `vnew` and `dir` unchanged.
  - Otherwise: latch target, go to STEP.
- State STEP (one cycle):
  - `dir` <= (target > `pos`).
  - `pos` <= `pos` ± 1 toward the target.
  - `vnew` <= table[new `pos`].
  - Counter <= DWELL-1; go to DWELL.
- State DWELL: counter decrements each edge. On the edge where the counter is 0:
  - `pos` == target, or `halt` is high: pulse `done`, go to IDLE.
  - Otherwise: go to STEP.
- `vnew` and `dir` change on the same edge, only in STEP; they are stable at all other times.
- Steps are always ±1 with no wrap-around. A 5 -> 0 request walks down through 4,3,2,1 rather than jumping.
- `halt` is sampled only at the end of a dwell. `pos` always reflects the last applied pattern; the target is discarded.
- `req_valid` is ignored while `busy`; there is no queueing. A request held across the return to IDLE is accepted in the first IDLE cycle.
- `halt` high while IDLE has no effect on request acceptance.

## Timing
- Request accepted at edge t: first `vnew` change at edge t+1.
- Subsequent `vnew` changes every DWELL+1 cycles.
- A k-step request asserts `done` in the cycle after edge t+k·(DWELL+1). `req_ready` rises in that same cycle.
- `done`/`err` latency for an immediate (0-step or rejected) request: asserted in the cycle after the accepting edge.
- The minimum spacing between `vnew` changes is DWELL+1 >= 5 cycles. This exceeds the downstream four-cycle sequence plus the return to its idle state.
- All outputs are registered; there are no combinational paths from inputs to outputs except `req_ready`, which is decoded from state only.

## Test plan
- Reset then idle: assert `rst` 2 cycles -> `vnew`=000011, `pos`=0, `req_ready`=1, `busy`=0, no `done`/`err`.
- Upward walk, DWELL=8, request pos 3 at edge t:
  - `vnew`=000110 at t+1, 001100 at t+10, 011000 at t+19, each with `dir`=1.
  - `done` pulses after t+27.
- Downward walk from pos 5 to 0: five patterns in descending order, `dir`=0 on each step, spacing exactly 9 cycles, no wrap to 000011 directly from 100001.
- Boundary requests:
  - `req_pos`=6 -> `err` pulse, `pos` unchanged.
  - `req_pos`=7 -> `err` pulse, `pos` unchanged.
  - `req_pos` == `pos` -> `done` pulse next cycle, `vnew` unchanged.
- Halt and ignore: request 0->4 with `halt` raised during the second dwell -> stops at `pos`=2, `done` pulses. A `req_valid` pulse sent mid-dwell is ignored (`req_ready`=0, no effect).
- Reset mid-walk: `rst` during DWELL of step 0->1->2 -> next edge `pos`=0, `vnew`=000011, IDLE, no `done`.
